// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: controller state encoding
// and helpers that derive address field widths from the cache geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } cache_state_e;

  localparam int BYTE_OFF_W = 2;
  localparam int WORD_W     = 32;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int line_words);
    return addr_w - BYTE_OFF_W - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Cache data array: LINES x LINE_WORDS 32-bit words, one word-granular
// write port and an asynchronous read port.
module cache_line_ram
  import cache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clock,
  input  logic                            we,
  input  logic [index_w(LINES)-1:0]       w_idx,
  input  logic [offset_w(LINE_WORDS)-1:0] w_off,
  input  logic [WORD_W-1:0]               wdata,
  input  logic [index_w(LINES)-1:0]       r_idx,
  input  logic [offset_w(LINE_WORDS)-1:0] r_off,
  output logic [WORD_W-1:0]               rdata
);

  logic [WORD_W-1:0] mem_q [LINES*LINE_WORDS];

  // Single word write per cycle; contents are not reset.
  always_ff @(posedge clock) begin
    if (we) mem_q[{w_idx, w_off}] <= wdata;
  end

  assign rdata = mem_q[{r_idx, r_off}];

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate cache. Tags, valid bits
// and the IDLE/FILL/WRITE controller live here; word storage is in
// cache_line_ram.
module direct_mapped_cache
  import cache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              stall,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int OFF_W = offset_w(LINE_WORDS);
  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  cache_state_e          state_q, state_d;
  logic [OFF_W-1:0]      beat_q, beat_d;
  logic [ADDR_W-3:0]     req_addr_q, req_addr_d;
  logic [31:0]           req_data_q, req_data_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  wr_done_q, wr_done_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [LINES];

  logic [OFF_W-1:0]      cur_off, req_off, ram_w_off;
  logic [IDX_W-1:0]      cur_idx, req_idx;
  logic [TAG_W-1:0]      cur_tag, req_tag;
  logic                  cur_hit, req_hit;
  logic                  tag_we, ram_we;
  logic [31:0]           ram_wdata, ram_rdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  assign cur_off = address[2 +: OFF_W];
  assign cur_idx = address[2 + OFF_W +: IDX_W];
  assign cur_tag = address[ADDR_W-1 -: TAG_W];
  assign req_off = req_addr_q[0 +: OFF_W];
  assign req_idx = req_addr_q[OFF_W +: IDX_W];
  assign req_tag = req_addr_q[ADDR_W-3 -: TAG_W];

  assign cur_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  cache_line_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .w_idx (req_idx),
    .w_off (ram_w_off),
    .wdata (ram_wdata),
    .r_idx (cur_idx),
    .r_off (cur_off),
    .rdata (ram_rdata)
  );

  // Controller state and request capture registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      flush_pend_q <= 1'b0;
      wr_done_q    <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      flush_pend_q <= flush_pend_d;
      wr_done_q    <= wr_done_d;
      valid_q      <= valid_d;
    end
  end

  // Tag store has no reset; valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (tag_we) tag_q[req_idx] <= req_tag;
  end

  // Next-state, array write controls and core/memory outputs.
  // wr_done_q marks the single IDLE cycle after a write completes, in which
  // the still-held write request is acknowledged rather than restarted.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    flush_pend_d = flush_pend_q;
    wr_done_d    = 1'b0;
    valid_d      = valid_q;
    tag_we       = 1'b0;
    ram_we       = 1'b0;
    ram_w_off    = req_off;
    ram_wdata    = mem_rdata;
    stall        = 1'b0;
    data_out     = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    unique case (state_q)
      ST_IDLE: begin
        flush_pend_d = 1'b0;
        if (!(wr_done_q && write)) begin
          stall = (read | write) & ~(read & cur_hit & ~write);
          if (read && !write && cur_hit) data_out = ram_rdata;
          if (write) begin
            state_d    = ST_WRITE;
            req_addr_d = address[ADDR_W-1:2];
            req_data_d = data_in;
          end else if (read && !cur_hit) begin
            state_d    = ST_FILL;
            beat_d     = '0;
            req_addr_d = address[ADDR_W-1:2];
          end
        end
        if (flush) valid_d = '0;
      end
      ST_FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat_q, 2'b00};
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          ram_we    = 1'b1;
          ram_w_off = beat_q;
          beat_d    = beat_q + OFF_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d      = ST_IDLE;
            tag_we       = 1'b1;
            flush_pend_d = 1'b0;
            if (flush || flush_pend_q) valid_d = '0;
            else valid_d[req_idx] = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {req_addr_q, 2'b00};
        mem_wdata = req_data_q;
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          if (req_hit) begin
            ram_we    = 1'b1;
            ram_wdata = req_data_q;
          end
          state_d      = ST_IDLE;
          wr_done_d    = 1'b1;
          flush_pend_d = 1'b0;
          if (flush || flush_pend_q) valid_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
